// File: rtl/aes_ctr_stream.sv
`default_nettype none
// ============================================================================
// Module      : aes_ctr_stream
// Description : AES-CTR streaming wrapper. Issues counter blocks to an
//               external fixed-latency AES encrypt pipeline, queues the
//               matching input data, XORs returned keystream with it and
//               presents results through a first-word-fall-through FIFO.
//               Credit-based flow control bounds total occupancy; flush
//               drops in-flight keystream returns.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_ctr_stream #(
    parameter int DEPTH     = 8,
    parameter int CTR_WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [127:0]             in_block,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [127:0]             out_block,
    input  logic                     ctr_load,
    input  logic [127:0]             ctr_in,
    input  logic                     flush,
    output logic                     cipher_in_valid,
    output logic [127:0]             cipher_in_block,
    input  logic                     cipher_out_valid,
    input  logic [127:0]             cipher_out_block,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    // Bits of the counter that take part in the increment; upper bits hold.
    localparam logic [127:0]  CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

    logic [127:0]  ctr_reg;
    logic          init_done;
    logic [AW:0]   credits;
    logic [AW:0]   outstanding;
    logic [AW:0]   drop_cnt;

    logic [127:0]  dq_mem [DEPTH];
    logic [AW-1:0] dq_wr, dq_rd;
    logic [AW:0]   dq_cnt;

    logic [127:0]  of_mem [DEPTH];
    logic [AW-1:0] of_wr, of_rd;
    logic [AW:0]   of_cnt;

    logic          accept;
    logic          ret_live;
    logic          ret_any;
    logic          dq_pop;
    logic          ret_err;
    logic          of_pop;
    logic [127:0]  ctr_next;

    assign in_ready = !rst && init_done && (credits < DEPTH_C) && !ctr_load
                      && !flush && (drop_cnt == '0);
    assign accept   = in_valid && in_ready;

    assign cipher_in_valid = accept;
    assign cipher_in_block = ctr_reg;

    // A return is "live" only when it is not being discarded after a flush.
    assign ret_live = cipher_out_valid && (drop_cnt == '0);
    // Stray returns (nothing outstanding) must not underflow the tracker.
    assign ret_any  = cipher_out_valid && (outstanding != '0);
    assign dq_pop   = ret_live && (dq_cnt != '0);
    assign ret_err  = ret_live && (dq_cnt == '0);

    assign out_valid = (of_cnt != '0);
    assign out_block = of_mem[of_rd];
    assign of_pop    = out_valid && out_ready;
    assign count     = credits;

    assign ctr_next = (ctr_reg & ~CTR_MASK) | ((ctr_reg + 128'd1) & CTR_MASK);

    // Counter register: load has priority; load and accept never coincide.
    always_ff @(posedge clk) begin
        if (rst)           ctr_reg <= '0;
        else if (ctr_load) ctr_reg <= ctr_in;
        else if (accept)   ctr_reg <= ctr_next;
    end

    // Holds in_ready low for the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) init_done <= 1'b0;
        else     init_done <= 1'b1;
    end

    // Credits: taken on accept, returned when the result leaves the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush)          credits <= '0;
        else if (accept && !of_pop) credits <= credits + 1'b1;
        else if (!accept && of_pop) credits <= credits - 1'b1;
    end

    // Issued-but-unreturned tracking and post-flush discard counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (accept && !ret_any)      outstanding <= outstanding + 1'b1;
            else if (!accept && ret_any) outstanding <= outstanding - 1'b1;
            // A return coincident with flush counts as already returned.
            if (flush)
                drop_cnt <= outstanding - {{AW{1'b0}}, ret_any};
            else if (cipher_out_valid && drop_cnt != '0)
                drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // Data queue storage: plaintext/ciphertext waiting for keystream.
    always_ff @(posedge clk) begin
        if (accept) dq_mem[dq_wr] <= in_block;
    end

    // Data queue pointers.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dq_wr  <= '0;
            dq_rd  <= '0;
            dq_cnt <= '0;
        end else begin
            if (accept) dq_wr <= dq_wr + 1'b1;
            if (dq_pop) dq_rd <= dq_rd + 1'b1;
            if (accept && !dq_pop)      dq_cnt <= dq_cnt + 1'b1;
            else if (!accept && dq_pop) dq_cnt <= dq_cnt - 1'b1;
        end
    end

    // Output FIFO storage: XOR result registered on keystream return.
    always_ff @(posedge clk) begin
        if (dq_pop) of_mem[of_wr] <= dq_mem[dq_rd] ^ cipher_out_block;
    end

    // Output FIFO pointers; credits guarantee it never overflows.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            of_wr  <= '0;
            of_rd  <= '0;
            of_cnt <= '0;
        end else begin
            if (dq_pop) of_wr <= of_wr + 1'b1;
            if (of_pop) of_rd <= of_rd + 1'b1;
            if (dq_pop && !of_pop)      of_cnt <= of_cnt + 1'b1;
            else if (!dq_pop && of_pop) of_cnt <= of_cnt - 1'b1;
        end
    end

    // Sticky error on a keystream return with no matching data.
    always_ff @(posedge clk) begin
        if (rst)          err <= 1'b0;
        else if (ret_err) err <= 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_ctr_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_ctr_stream
// Description : Directed self-checking bench for aes_ctr_stream with a
//               28-cycle cipher model (keystream = ctr ^ A5..A5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_ctr_stream;

    localparam int DEPTH     = 8;
    localparam int CTR_WIDTH = 32;
    localparam int LAT       = 28;
    localparam logic [127:0] KS = {16{8'hA5}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         ctr_load;
    logic [127:0] ctr_in;
    logic         flush;
    logic         cipher_in_valid;
    logic [127:0] cipher_in_block;
    logic         cipher_out_valid;
    logic [127:0] cipher_out_block;
    logic [$clog2(DEPTH):0] count;
    logic         err;
    logic         inject;

    int vectors     = 0;
    int miscompares = 0;

    aes_ctr_stream #(.DEPTH(DEPTH), .CTR_WIDTH(CTR_WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_block         (in_block),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_block        (out_block),
        .ctr_load         (ctr_load),
        .ctr_in           (ctr_in),
        .flush            (flush),
        .cipher_in_valid  (cipher_in_valid),
        .cipher_in_block  (cipher_in_block),
        .cipher_out_valid (cipher_out_valid),
        .cipher_out_block (cipher_out_block),
        .count            (count),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Cipher model: fixed-latency pipeline, flushed by rst.
    logic [LAT-1:0] pv;
    logic [127:0]   pd [LAT];
    always @(posedge clk) begin
        if (rst) pv <= '0;
        else     pv <= {pv[LAT-2:0], cipher_in_valid};
        pd[0] <= cipher_in_block ^ KS;
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
    assign cipher_out_valid = pv[LAT-1] | inject;
    assign cipher_out_block = pd[LAT-1];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, 128'(out_valid), 128'd1);
    endtask

    initial begin
        int n;
        int acc;
        int seen;
        rst = 1'b1; in_valid = 1'b1; in_block = '0; out_ready = 1'b1;
        ctr_load = 1'b0; ctr_in = '0; flush = 1'b0; inject = 1'b0;

        // Reset state, with in_valid asserted throughout
        repeat (3) tick();
        #1;
        check("rst_in_ready", 128'(in_ready), 0);
        check("rst_cin_valid", 128'(cipher_in_valid), 0);
        check("rst_out_valid", 128'(out_valid), 0);
        check("rst_count", 128'(count), 0);
        check("rst_err", 128'(err), 0);
        in_valid = 1'b0;
        tick(); rst = 1'b0; #1;
        check("rst_fall_in_ready", 128'(in_ready), 0);
        tick(); #1;
        check("post_rst_in_ready", 128'(in_ready), 1);

        // Single block latency and value
        ctr_load = 1'b1; ctr_in = '0; #1;
        check("load_in_ready", 128'(in_ready), 0);
        tick(); ctr_load = 1'b0; in_valid = 1'b1; in_block = 128'h1; #1;
        check("single_cin_valid", 128'(cipher_in_valid), 1);
        check("single_cin_block", cipher_in_block, 128'h0);
        tick(); in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin tick(); n++; end
        check("single_latency", 128'(n), 29);
        check("single_out_block", out_block, {{15{8'hA5}}, 8'hA4});
        tick(); #1;
        check("single_one_cycle", 128'(out_valid), 0);

        // Backpressure: 10 offered, 8 accepted (ctr continues from 1)
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); in_valid = 1'b1; in_block = 128'h100 + 128'(i); #1;
            if (in_ready) acc++;
        end
        tick(); in_valid = 1'b0; #1;
        check("bp_accepts", 128'(acc), 8);
        check("bp_count", 128'(count), 8);
        check("bp_in_ready_low", 128'(in_ready), 0);
        repeat (40) tick();
        check("bp_out_valid", 128'(out_valid), 1);
        check("bp_blk0", out_block, 128'h100 ^ (128'd1 ^ KS));
        out_ready = 1'b1;
        tick(); out_ready = 1'b0; #1;
        check("bp_count_after_pop", 128'(count), 7);
        check("bp_in_ready_after_pop", 128'(in_ready), 1);
        out_ready = 1'b1; #1;
        for (int k = 1; k < 8; k++) begin
            check("bp_drain_valid", 128'(out_valid), 1);
            check("bp_drain_blk", out_block, (128'h100 + 128'(k)) ^ ((128'd1 + 128'(k)) ^ KS));
            tick();
        end
        check("bp_drained_count", 128'(count), 0);

        // Counter wrap within the low 32 bits
        ctr_load = 1'b1; ctr_in = 128'h1_FFFF_FFFF;
        tick(); ctr_load = 1'b0; in_valid = 1'b1; in_block = '0; #1;
        check("wrap_cin0", cipher_in_block, 128'h1_FFFF_FFFF);
        tick(); #1;
        check("wrap_cin1", cipher_in_block, 128'h1_0000_0000);
        tick(); in_valid = 1'b0;
        wait_out("wrap_wait");
        check("wrap_out0", out_block, 128'h1_FFFF_FFFF ^ KS);
        tick();
        check("wrap_out1", out_block, 128'h1_0000_0000 ^ KS);
        tick();
        check("wrap_count", 128'(count), 0);

        // Flush with 3 blocks in flight
        for (int i = 0; i < 3; i++) begin
            tick(); in_valid = 1'b1; in_block = 128'(i);
        end
        tick(); in_valid = 1'b0;
        repeat (4) tick();
        flush = 1'b1; #1;
        check("flush_in_ready", 128'(in_ready), 0);
        tick(); flush = 1'b0; #1;
        check("flush_drop_cnt", 128'(dut.drop_cnt), 3);
        check("flush_count", 128'(count), 0);
        seen = 0; n = 0;
        while (!in_ready && n < 60) begin
            if (out_valid) seen = 1;
            tick(); n++;
        end
        check("flush_no_output", 128'(seen), 0);
        check("flush_ready_back", 128'(in_ready), 1);
        check("flush_end_count", 128'(count), 0);
        check("flush_err", 128'(err), 0);
        in_valid = 1'b1; in_block = 128'h55; #1;
        check("flush_ctr_kept", cipher_in_block, 128'h1_0000_0004);
        tick(); in_valid = 1'b0;
        wait_out("flush_next_wait");
        check("flush_next_out", out_block, 128'h55 ^ (128'h1_0000_0004 ^ KS));
        tick();

        // Reset with 4 blocks in flight
        for (int i = 0; i < 4; i++) begin
            tick(); in_valid = 1'b1; in_block = 128'h9 + 128'(i);
        end
        tick(); in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1; in_valid = 1'b1;
        tick(); #1;
        check("midrst_in_ready", 128'(in_ready), 0);
        check("midrst_cin_valid", 128'(cipher_in_valid), 0);
        check("midrst_out_valid", 128'(out_valid), 0);
        check("midrst_count", 128'(count), 0);
        in_valid = 1'b0;
        tick(); rst = 1'b0;
        tick(); in_valid = 1'b1; in_block = 128'h77; #1;
        check("midrst_cin_block", cipher_in_block, 128'h0);
        tick(); in_valid = 1'b0;
        wait_out("midrst_wait");
        check("midrst_out", out_block, 128'h77 ^ KS);
        check("midrst_err", 128'(err), 0);
        tick();

        // Stray keystream return sets sticky err
        inject = 1'b1;
        tick(); inject = 1'b0; #1;
        check("stray_err", 128'(err), 1);
        check("stray_out_valid", 128'(out_valid), 0);
        repeat (5) tick();
        check("stray_err_sticky", 128'(err), 1);
        check("stray_out_valid_late", 128'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/aes_ctr_stream.md
AES_CTR_STREAM -- requirements
Module: aes_ctr_stream

Interface
REQ-001 Parameter DEPTH, default 8, max blocks in flight plus buffered; power of two, 2..64.
REQ-002 Parameter CTR_WIDTH, default 128, count of low counter bits that increment; 32..128.
REQ-003 Port clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Port in_valid / in_ready / in_block  in / out / in  1/1/128  plaintext or ciphertext input handshake.
REQ-006 Port out_valid / out_ready / out_block  out / in / out  1/1/128  result output handshake.
REQ-007 Port ctr_load / ctr_in  in / in  1/128  counter load pulse and value.
REQ-008 Port flush  in  1  pulse; discards all buffered and in-flight blocks.
REQ-009 Port cipher_in_valid / cipher_in_block  out / out  1/128  counter block sent to the external fixed-latency AES encrypt pipeline.
REQ-010 Port cipher_out_valid / cipher_out_block  in / in  1/128  keystream returned in issue order.
REQ-011 Port count  out  $clog2(DEPTH)+1  credits in use; err  out  1  sticky protocol error.

Function
REQ-012 Accept is in_valid && in_ready on a rising edge.
REQ-013 in_ready = !rst && credits < DEPTH && !ctr_load && !flush && drop_cnt == 0.
REQ-014 On accept, same cycle, combinationally: cipher_in_valid = 1 and cipher_in_block = ctr_reg; in_block is pushed to the data queue (DEPTH entries).
REQ-015 On accept, ctr_reg[CTR_WIDTH-1:0] increments modulo 2^CTR_WIDTH; bits above CTR_WIDTH are unchanged. 2^CTR_WIDTH-1 wraps to 0 with no carry.
REQ-016 ctr_load loads ctr_reg <= ctr_in; in_ready is low in that cycle, so a load and an accept never coincide.
REQ-017 On cipher_out_valid with drop_cnt == 0 and the data queue non-empty:
- pop the queue head;
- push head XOR cipher_out_block into the output FIFO (DEPTH entries), registered.
REQ-018 Output FIFO is first-word fall-through:
- out_valid = FIFO non-empty;
- out_block = FIFO head;
- pop on out_valid && out_ready.
REQ-019 End-to-end latency is cipher latency + 1: a block whose keystream returns at cycle T is presented at T+1.
REQ-020 Credits increment on accept and decrement on output pop; both in one cycle leave credits unchanged.
REQ-021 A full output FIFO can never overflow, because credits bound the total occupancy.
REQ-022 out_block data is held stable while out_valid && !out_ready.
REQ-023 flush, next cycle:
- clears the data queue, output FIFO and credits;
- loads drop_cnt with the number of issued-but-unreturned blocks;
- leaves ctr_reg unchanged.
REQ-024 While drop_cnt > 0, each cipher_out_valid is discarded and decrements drop_cnt; in_ready stays low until drop_cnt == 0.
REQ-025 flush coincident with a cipher return: that return is counted as already returned and is not included in drop_cnt.
REQ-026 cipher_out_valid with drop_cnt == 0 and an empty data queue sets err; the FIFOs are not modified.
REQ-027 err is cleared only by rst.

Reset
REQ-028 While rst is high, and in the first cycle after it falls:
- in_ready=0, out_valid=0, cipher_in_valid=0, count=0, err=0;
- ctr_reg=0, drop_cnt=0; all queues empty.
REQ-029 Reset mid-operation abandons in-flight blocks; the bench flushes its cipher model on rst.
REQ-030 out_block after reset is don't-care while out_valid=0.

Verification (cipher model: 28-cycle pipeline, keystream = ctr XOR 128'hA5A5...A5)
REQ-031 ctr_load 128'h0, one block 128'h1, out_ready=1:
- cipher_in_block = 0;
- out_valid high exactly 29 cycles after accept with out_block = 128'hA5..A4, for one cycle.
REQ-032 DEPTH=8, 10 back-to-back blocks, out_ready=0:
- in_ready drops after 8 accepts; count = 8;
- after 1 pop, in_ready rises and count = 7.
REQ-033 CTR_WIDTH=32, ctr_load 128'h1_FFFFFFFF, two accepts:
- cipher_in_block = 128'h1_FFFFFFFF, then 128'h1_00000000.
REQ-034 3 blocks issued, flush 5 cycles later:
- out_valid stays 0; drop_cnt = 3; the 3 returns are discarded;
- in_ready returns next cycle, count = 0, err = 0.
REQ-035 cipher_out_valid injected with nothing issued: err = 1 and sticky; out_valid stays 0.
REQ-036 rst asserted with 4 blocks in flight:
- all outputs take reset values next cycle;
- a new block after reset completes correctly.
